// File: rtl/return_addr_stack.sv
// Return-address stack for the 16-bit CPU: circular LIFO of call return
// addresses (PC+1), with a bus-drive enable and sticky overflow/underflow flags.
module return_addr_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           pc_in,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       drive,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           out,
  output logic                       bus_oe,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    tp;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] ret_addr;
  logic             tail_call;
  logic             do_push;
  logic             do_pop;

  assign top_idx  = tp - PTR_ONE;
  assign ret_addr = pc_in + WIDTH'(1);

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign out    = empty ? '0 : mem[top_idx];
  assign bus_oe = drive & ~empty;

  // push+pop on an empty stack degrades to a plain push
  assign tail_call = push & pop & ~empty;
  assign do_push   = push & ~tail_call;
  assign do_pop    = pop & ~push;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[tp] <= ret_addr;
    else if (tail_call)
      mem[top_idx] <= ret_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) begin
        tp <= tp + PTR_ONE;
        if (!full)
          count <= count + CNT_ONE;
      end else if (do_pop && !empty) begin
        tp    <= tp - PTR_ONE;
        count <= count - CNT_ONE;
      end

      // a same-cycle error event takes priority over the clear
      if (do_push && full)
        overflow <= 1'b1;
      else if (err_clr)
        overflow <= 1'b0;

      if (do_pop && empty)
        underflow <= 1'b1;
      else if (err_clr)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_return_addr_stack.sv
// Testbench for return_addr_stack: directed test-plan steps plus random
// push/pop traffic, checked against a queue-based LIFO reference model.
module tb_return_addr_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] pc_in;
  logic             push, pop, drive, err_clr;
  logic [WIDTH-1:0] out;
  logic             bus_oe, empty, full, overflow, underflow;
  logic [CW-1:0]    count;

  int errors = 0;
  int checks = 0;

  // reference model: newest entry at the back of the queue
  logic [WIDTH-1:0] q[$];
  bit               m_ov, m_uf;

  return_addr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .push(push), .pop(pop),
    .drive(drive), .err_clr(err_clr), .out(out), .bus_oe(bus_oe),
    .empty(empty), .full(full), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_ov = 0;
    m_uf = 0;
  endfunction

  function automatic void model_step(input logic p, input logic po,
                                     input logic [WIDTH-1:0] pc, input logic ec);
    logic [WIDTH-1:0] v;
    v = pc + 16'd1;
    if (ec) begin
      m_ov = 0;
      m_uf = 0;
    end
    if (p && po && q.size() != 0) begin
      q[q.size()-1] = v;
    end else if (p) begin
      if (q.size() == DEPTH) begin
        void'(q.pop_front());
        m_ov = 1;
      end
      q.push_back(v);
    end else if (po) begin
      if (q.size() == 0) m_uf = 1;
      else void'(q.pop_back());
    end
  endfunction

  task automatic check_state(input string tag);
    logic [WIDTH-1:0] e_out;
    e_out = (q.size() == 0) ? '0 : q[q.size()-1];
    chk({tag, ".out"},       32'(out),       32'(e_out));
    chk({tag, ".count"},     32'(count),     32'(q.size()));
    chk({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ov));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_uf));
    chk({tag, ".bus_oe"},    32'(bus_oe),    32'(drive && q.size() != 0));
  endtask

  // apply one cycle of strobes (called at posedge+1), then check after the edge
  task automatic cyc(input string tag, input logic p, input logic po,
                     input logic [WIDTH-1:0] pc, input logic d, input logic ec);
    push = p; pop = po; pc_in = pc; drive = d; err_clr = ec;
    model_step(p, po, pc, ec);
    @(posedge clk);
    #1;
    push = 0; pop = 0; err_clr = 0;
    check_state(tag);
  endtask

  initial begin
    rst_n = 0; push = 0; pop = 0; drive = 0; err_clr = 0; pc_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst_n = 1;

    // asynchronous reset mid-cycle after three pushes
    cyc("rst_p0", 1, 0, 16'h1000, 0, 0);
    cyc("rst_p1", 1, 0, 16'h2000, 0, 0);
    cyc("rst_p2", 1, 0, 16'h3000, 0, 0);
    #2;
    drive = 1;
    rst_n = 0;
    model_reset();
    #1;
    check_state("rst_async");
    chk("rst_bus_oe_const", 32'(bus_oe), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    drive = 0;

    // basic LIFO
    cyc("lifo_p0", 1, 0, 16'h0010, 0, 0);
    cyc("lifo_p1", 1, 0, 16'h0020, 0, 0);
    cyc("lifo_p2", 1, 0, 16'h0030, 0, 0);
    chk("lifo_top_const", 32'(out), 32'h0031);
    cyc("lifo_pop0", 0, 1, '0, 1, 0);
    chk("lifo_pop0_const", 32'(out), 32'h0021);
    cyc("lifo_pop1", 0, 1, '0, 1, 0);
    cyc("lifo_pop2", 0, 1, '0, 1, 0);
    chk("lifo_empty_const", 32'(empty), 32'd1);

    // overflow: 9 pushes into DEPTH=8
    for (int i = 0; i <= DEPTH; i++) cyc("ovf_push", 1, 0, 16'(i), 0, 0);
    chk("ovf_flag_const", 32'(overflow), 32'd1);
    chk("ovf_top_const", 32'(out), 32'h0009);
    for (int i = 0; i < DEPTH; i++) cyc("ovf_pop", 0, 1, '0, 0, 0);
    chk("ovf_drain_const", 32'(empty), 32'd1);
    cyc("ovf_clr", 0, 0, '0, 0, 1);

    // underflow and sticky clear priority
    cyc("unf_pop", 0, 1, '0, 0, 0);
    chk("unf_flag_const", 32'(underflow), 32'd1);
    cyc("unf_clr", 0, 0, '0, 0, 1);
    cyc("unf_clr_pop", 0, 1, '0, 0, 1);
    chk("unf_priority_const", 32'(underflow), 32'd1);
    cyc("unf_clr2", 0, 0, '0, 0, 1);

    // tail call, non-empty then empty
    cyc("tail_p", 1, 0, 16'h0100, 0, 0);
    cyc("tail_pp", 1, 1, 16'h0200, 0, 0);
    chk("tail_out_const", 32'(out), 32'h0201);
    cyc("tail_pop", 0, 1, '0, 0, 0);
    cyc("tail_empty_pp", 1, 1, 16'h0300, 0, 0);
    chk("tail_empty_unf_const", 32'(underflow), 32'd0);
    cyc("tail_pop2", 0, 1, '0, 0, 0);

    // address wrap
    cyc("wrap_p", 1, 0, 16'hFFFF, 0, 0);
    chk("wrap_empty_const", 32'(empty), 32'd0);
    cyc("wrap_drive", 0, 0, '0, 1, 0);
    cyc("wrap_pop", 0, 1, '0, 1, 0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

Hardware return-address stack for the 16-bit CPU. It handles the opposite direction of the program counter's bus-load path. On a call it captures the current PC plus one. On a return it presents the saved address so the program counter can load it from the bus. The block sits beside the program counter, and the control unit drives its push/pop strobes and bus-drive enable.

## Interface
- WIDTH, 16, address width; must match the PC width
- DEPTH, 8, number of stack entries; power of two, minimum 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- pc_in  input  WIDTH  current PC value, sampled on push
- push  input  1  call strobe, one cycle per call
- pop  input  1  return strobe, one cycle per return
- drive  input  1  control-unit request to place the top-of-stack on the bus
- err_clr  input  1  synchronous clear of the sticky error flags
- out  output  WIDTH  top-of-stack value (return address)
- bus_oe  output  1  bus output enable; equals drive AND NOT empty
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- count  output  clog2(DEPTH)+1  number of valid entries
- overflow  output  1  sticky: a push occurred while full
- underflow  output  1  sticky: a pop occurred while empty

## Operation
- Storage is a circular buffer of DEPTH entries with a top pointer `tp`. `tp` indexes the next free slot, modulo DEPTH.
- `out` = mem[tp-1] when not empty, else 0. It is a combinational read of registered storage.
- Push only (no pop): mem[tp] <= pc_in + 1, truncated to WIDTH so 16'hFFFF wraps to 16'h0000. Then tp <= tp+1 and count <= count+1.
- Push while full: the write still happens and overwrites the oldest entry; tp advances; count stays at DEPTH; overflow <= 1.
- Pop only (no push), not empty: tp <= tp-1 and count <= count-1. Storage is unchanged.
- Pop while empty: no state change except underflow <= 1. `out` stays 0.
- Push and pop in the same cycle means a tail call:
  - mem[tp-1] <= pc_in + 1, replacing the top; tp and count are unchanged.
  - If empty, it behaves as a plain push; underflow is not set.
- `out` is meaningful to the consumer in the cycle the control unit asserts drive, before pop. The required sequence is drive, then pop in the same or a later cycle; the PC loads from the bus on the same edge as the pop.
- err_clr clears overflow and underflow. If an error event occurs in the same cycle, the error wins (the flag is set).
- Pointer arithmetic is modulo DEPTH. Count is saturating in the range 0..DEPTH.

## Timing
- Reset (rst_n low, asynchronous): tp=0, count=0, overflow=0, underflow=0, empty=1, full=0, out=0, bus_oe=0. Memory contents are don't-care and are never visible while empty.
- Reset deasserts synchronously to clk (external synchronizer). The first push is accepted on the first rising edge with rst_n high.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Push/pop latency: state updates on the rising edge; the new `out`, count, and flags are visible immediately after that edge.
- bus_oe is combinational from drive and empty, with no added cycle.
- Back-to-back push/pop every cycle is supported; there are no stall or bubble cycles.
- A glitch-free `out` is required only after the clock edge settles; the PC samples it on the following edge.

## Test plan
- **Reset:** Assert rst_n=0 mid-clock after three pushes. Expect count=0, empty=1, out=0, and bus_oe=0 even with drive=1, all before the next edge.
- **Basic LIFO:** Push pc_in=16'h0010, then 16'h0020, then 16'h0030. Expect out=16'h0031 and count=3. Pop gives out=16'h0021; pop gives 16'h0011; pop gives empty=1 and out=0.
- **Overflow:**
  - With DEPTH=8, push pc_in=0..8 (9 pushes). Expect full=1, count=8, overflow=1, out=16'h0009.
  - Then pop 8 times. Expect out to go 9,8,...,2, then empty. Entry 1 is lost.
- **Underflow:**
  - Pop when empty. Expect underflow=1, count=0, out=0.
  - Pulse err_clr. Expect underflow=0.
  - err_clr together with an empty pop. Expect underflow stays 1.
- **Simultaneous push+pop:** Push 16'h0100, then push+pop with pc_in=16'h0200. Expect count=1 and out=16'h0201. Repeat on an empty stack. Expect count=1, out=pc_in+1, underflow=0.
- **Address wrap:** Push pc_in=16'hFFFF. Expect out=16'h0000 and empty=0. Assert drive=1. Expect bus_oe=1.
